// File: rtl/gpio_pcint.sv
// GPIO block with NUM_PORTS 8-bit ports (PIN/DDR/PORT/PCMSK registers) and
// per-port pin-change interrupt flags, on a simple valid/ready memory bus.
module gpio_pcint #(
  parameter int          NUM_PORTS   = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0040,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mem_valid,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic [3:0]             mem_wstrb,
  output logic [31:0]            mem_rdata,
  output logic                   mem_ready,
  input  logic [8*NUM_PORTS-1:0] pin_in,
  output logic [8*NUM_PORTS-1:0] pin_out,
  output logic [8*NUM_PORTS-1:0] pin_dir,
  output logic                   irq
);
  localparam int W  = 8 * NUM_PORTS;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM_DONE  = CW'(SYNC_STAGES + 1);
  localparam logic [29:0]   CTRL_WORD = 30'(NUM_PORTS);

  logic [W-1:0]         sync_q [SYNC_STAGES];
  logic [W-1:0]         sync_d [SYNC_STAGES];
  logic [W-1:0]         prev_q, prev_d;
  logic [W-1:0]         ddr_q, ddr_d;
  logic [W-1:0]         port_q, port_d;
  logic [W-1:0]         pcmsk_q, pcmsk_d;
  logic [NUM_PORTS-1:0] pcifr_q, pcifr_d;
  logic [NUM_PORTS-1:0] pcicr_q, pcicr_d;
  logic [CW-1:0]        arm_q, arm_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 irq_q, irq_d;

  logic [W-1:0]         sync_out;
  logic [W-1:0]         pin_change;
  logic [29:0]          word_off;
  logic                 sel;
  logic                 accept;
  logic                 wr;
  logic                 armed;
  logic [NUM_PORTS-1:0] pc_event;
  logic [NUM_PORTS-1:0] pcifr_clr;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign sync_out   = sync_q[SYNC_STAGES-1];
  assign pin_change = sync_out ^ prev_q;
  assign armed      = (arm_q == ARM_DONE);

  // Offset wraps for addresses below the base, so one compare bounds both ends.
  assign word_off = mem_addr[31:2] - BASE_ADDR[31:2];
  assign sel      = (word_off <= CTRL_WORD);
  // One access per mem_valid assertion: busy holds until the master releases valid.
  assign accept   = mem_valid & sel & ~ready_q & ~busy_q;
  assign wr       = accept & (|mem_wstrb);

  always_comb begin
    mem_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (word_off == 30'(p)) begin
        mem_rdata = {pcmsk_q[8*p +: 8], port_q[8*p +: 8], ddr_q[8*p +: 8], sync_out[8*p +: 8]};
      end
    end
    if (word_off == CTRL_WORD) begin
      mem_rdata[NUM_PORTS-1:0]  = pcifr_q;
      mem_rdata[8 +: NUM_PORTS] = pcicr_q;
    end
  end

  always_comb begin
    ddr_d     = ddr_q;
    port_d    = port_q;
    pcmsk_d   = pcmsk_q;
    pcicr_d   = pcicr_q;
    pcifr_clr = '0;
    if (wr) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (word_off == 30'(p)) begin
          // PIN toggle is applied first so a PORT byte in the same access overrides it.
          if (mem_wstrb[0]) port_d[8*p +: 8] = port_q[8*p +: 8] ^ mem_wdata[7:0];
          if (mem_wstrb[1]) ddr_d[8*p +: 8]  = mem_wdata[15:8];
          if (mem_wstrb[2]) port_d[8*p +: 8] = mem_wdata[23:16];
          if (mem_wstrb[3]) pcmsk_d[8*p +: 8] = mem_wdata[31:24];
        end
      end
      if (word_off == CTRL_WORD) begin
        if (mem_wstrb[0]) pcifr_clr = mem_wdata[NUM_PORTS-1:0];
        if (mem_wstrb[1]) pcicr_d   = mem_wdata[8 +: NUM_PORTS];
      end
    end
  end

  always_comb begin
    pc_event = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      pc_event[p] = armed & (|(pin_change[8*p +: 8] & pcmsk_q[8*p +: 8]));
    end
    // A new event outranks a same-cycle clear.
    pcifr_d = (pcifr_q & ~pcifr_clr) | pc_event;
    irq_d   = |(pcifr_q & pcicr_q);
    sync_d[0] = pin_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d  = sync_out;
    arm_d   = armed ? arm_q : arm_q + CW'(1);
    ready_d = accept;
    busy_d  = (busy_q | accept) & mem_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q  <= '0;
      ddr_q   <= '0;
      port_q  <= '0;
      pcmsk_q <= '0;
      pcifr_q <= '0;
      pcicr_q <= '0;
      arm_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      ddr_q   <= ddr_d;
      port_q  <= port_d;
      pcmsk_q <= pcmsk_d;
      pcifr_q <= pcifr_d;
      pcicr_q <= pcicr_d;
      arm_q   <= arm_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      irq_q   <= irq_d;
    end
  end

  assign mem_ready = ready_q;
  assign pin_out   = port_q;
  assign pin_dir   = ddr_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_pcint.sv
// Bench for gpio_pcint: directed register/interrupt scenarios followed by a
// randomized phase, all checked against a register-level model kept here.
module tb_gpio_pcint;
  localparam int          NP   = 3;
  localparam int          SS   = 2;
  localparam int          W    = 8 * NP;
  localparam logic [31:0] BASE = 32'h2000_0040;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_valid;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_rdata;
  logic         mem_ready;
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_out;
  logic [W-1:0] pin_dir;
  logic         irq;

  int vectors;
  int miscompares;

  // Reference model: register contents per port plus a delay line of sampled pins.
  logic [7:0]    m_ddr  [NP];
  logic [7:0]    m_port [NP];
  logic [7:0]    m_msk  [NP];
  logic [NP-1:0] m_flag;
  logic [NP-1:0] m_en;
  logic          m_ready;
  logic          m_open;
  logic          m_irq;
  logic [W-1:0]  hist [$];
  int            rel_edges;

  gpio_pcint #(.NUM_PORTS(NP), .BASE_ADDR(BASE), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .pin_in(pin_in), .pin_out(pin_out),
    .pin_dir(pin_dir), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = v;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
  endtask

  function automatic bit wordIndex(input logic [31:0] addr, output int idx);
    logic [31:0] a;
    a   = {addr[31:2], 2'b00};
    idx = 0;
    if (a < BASE || a >= BASE + 32'(4 * (NP + 1))) return 1'b0;
    idx = int'((a - BASE) >> 2);
    return 1'b1;
  endfunction

  function automatic logic [31:0] expRdata(input logic [31:0] addr);
    int           idx;
    logic [W-1:0] vis;
    logic [31:0]  r;
    r = '0;
    if (wordIndex(addr, idx)) begin
      if (idx < NP) begin
        vis = hist[SS-1];
        r = {m_msk[idx], m_port[idx], m_ddr[idx], vis[8*idx +: 8]};
      end else begin
        r[NP-1:0]  = m_flag;
        r[8 +: NP] = m_en;
      end
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int p = 0; p < NP; p++) begin
      m_ddr[p]  = 8'h00;
      m_port[p] = 8'h00;
      m_msk[p]  = 8'h00;
    end
    m_flag = '0;
    m_en   = '0;
    m_ready = 1'b0;
    m_open  = 1'b0;
    m_irq   = 1'b0;
    hist.delete();
    for (int i = 0; i <= SS; i++) hist.push_back('0);
    rel_edges = 0;
  endtask

  task automatic checkAll();
    logic [W-1:0] eo;
    logic [W-1:0] ed;
    for (int p = 0; p < NP; p++) begin
      eo[8*p +: 8] = m_port[p];
      ed[8*p +: 8] = m_ddr[p];
    end
    checkOutput("pin_out", 32'(pin_out), 32'(eo));
    checkOutput("pin_dir", 32'(pin_dir), 32'(ed));
    checkOutput("mem_ready", 32'(mem_ready), 32'(m_ready));
    checkOutput("irq", 32'(irq), 32'(m_irq));
  endtask

  // Checks read data, advances model and DUT by one edge, then checks outputs.
  task automatic clockEdge();
    logic [7:0]    n_ddr  [NP];
    logic [7:0]    n_port [NP];
    logic [7:0]    n_msk  [NP];
    logic [NP-1:0] n_flag, n_en, clr, evt;
    logic          n_ready, n_open, n_irq, acc, in_rst;
    logic [W-1:0]  chg, pin_s;
    int            idx;
    #1;
    checkOutput("mem_rdata", mem_rdata, expRdata(mem_addr));
    in_rst = !rst_n;
    pin_s  = pin_in;
    n_ddr = m_ddr;
    n_port = m_port;
    n_msk = m_msk;
    n_en = m_en;
    clr = '0;
    evt = '0;
    acc = mem_valid && wordIndex(mem_addr, idx) && !m_ready && !m_open;
    if (acc && mem_wstrb != 4'h0) begin
      if (idx < NP) begin
        if (mem_wstrb[0]) n_port[idx] = n_port[idx] ^ mem_wdata[7:0];
        if (mem_wstrb[1]) n_ddr[idx]  = mem_wdata[15:8];
        if (mem_wstrb[2]) n_port[idx] = mem_wdata[23:16];
        if (mem_wstrb[3]) n_msk[idx]  = mem_wdata[31:24];
      end else begin
        if (mem_wstrb[0]) clr  = mem_wdata[NP-1:0];
        if (mem_wstrb[1]) n_en = mem_wdata[8 +: NP];
      end
    end
    chg = hist[SS-1] ^ hist[SS];
    for (int p = 0; p < NP; p++) begin
      if (rel_edges >= SS + 1 && (chg[8*p +: 8] & m_msk[p]) != 8'h00) evt[p] = 1'b1;
    end
    n_flag  = (m_flag & ~clr) | evt;
    n_irq   = |(m_flag & m_en);
    n_ready = acc;
    n_open  = mem_valid && (m_open || acc);
    @(posedge clk);
    #1;
    if (in_rst) begin
      modelReset();
    end else begin
      m_ddr = n_ddr;
      m_port = n_port;
      m_msk = n_msk;
      m_flag = n_flag;
      m_en = n_en;
      m_ready = n_ready;
      m_open = n_open;
      m_irq = n_irq;
      hist.push_front(pin_s);
      void'(hist.pop_back());
      if (rel_edges < SS + 1) rel_edges++;
    end
    checkAll();
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    applyStimulus(1'b1, a, d, s);
    clockEdge();
    applyStimulus(1'b0, a, 32'h0, 4'h0);
    clockEdge();
  endtask

  initial begin
    int          rdy_cnt;
    logic [31:0] ra;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    pin_in = '1;
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    modelReset();

    $display("[TB] reset with all pins high, then release");
    repeat (3) clockEdge();
    rst_n = 1'b1;
    repeat (6) clockEdge();
    applyStimulus(1'b0, BASE + 32'(4 * NP), 32'h0, 4'h0);
    #1 checkOutput("pcifr_after_release", mem_rdata & 32'hFF, 32'h0);

    $display("[TB] access outside the register block");
    applyStimulus(1'b1, BASE + 32'd16, 32'hFFFF_FFFF, 4'hF);
    #1 checkOutput("outside_rdata", mem_rdata, 32'h0);
    repeat (2) clockEdge();
    checkOutput("outside_ready", 32'(mem_ready), 32'h0);
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    pin_in = '0;
    repeat (4) clockEdge();

    $display("[TB] DDR/PORT byte write and readback");
    busWrite(BASE + 32'd4, 32'h0055_FF00, 4'b0110);
    checkOutput("ddr1", 32'(pin_dir[15:8]), 32'hFF);
    checkOutput("port1", 32'(pin_out[15:8]), 32'h55);
    applyStimulus(1'b0, BASE + 32'd4, 32'h0, 4'h0);
    #1 checkOutput("readback1", mem_rdata, 32'h0055_FF00);

    $display("[TB] PIN toggle with mem_valid held");
    busWrite(BASE, 32'h000F_0000, 4'b0100);
    applyStimulus(1'b1, BASE, 32'h0000_003C, 4'b0001);
    rdy_cnt = 0;
    repeat (3) begin
      clockEdge();
      rdy_cnt += int'(mem_ready);
    end
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    clockEdge();
    rdy_cnt += int'(mem_ready);
    checkOutput("pin_toggle", 32'(pin_out[7:0]), 32'h33);
    checkOutput("ready_pulses", 32'(rdy_cnt), 32'd1);
    busWrite(BASE, 32'h00A5_00FF, 4'b0101);
    checkOutput("port_over_pin", 32'(pin_out[7:0]), 32'hA5);

    $display("[TB] pin change interrupt on port 2");
    busWrite(BASE + 32'd8, 32'h0100_0000, 4'b1000);
    busWrite(BASE + 32'd12, 32'h0000_0400, 4'b0010);
    pin_in[16] = 1'b1;
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'h0);
    clockEdge();
    clockEdge();
    checkOutput("pcifr_edge2", 32'(mem_rdata[7:0]), 32'h00);
    clockEdge();
    checkOutput("pcifr_edge3", 32'(mem_rdata[7:0]), 32'h04);
    checkOutput("irq_edge3", 32'(irq), 32'h0);
    clockEdge();
    checkOutput("irq_edge4", 32'(irq), 32'h1);
    busWrite(BASE + 32'd12, 32'h0000_0004, 4'b0001);
    checkOutput("irq_cleared", 32'(irq), 32'h0);
    checkOutput("pcifr_cleared", 32'(mem_rdata[7:0]), 32'h00);

    $display("[TB] event coinciding with flag clear");
    pin_in[16] = 1'b0;
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'h0);
    clockEdge();
    clockEdge();
    applyStimulus(1'b1, BASE + 32'd12, 32'h0000_0004, 4'b0001);
    clockEdge();
    checkOutput("event_beats_clear", 32'(mem_rdata[7:0]), 32'h04);
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'h0);
    clockEdge();
    busWrite(BASE + 32'd12, 32'h0000_0004, 4'b0001);
    clockEdge();

    $display("[TB] unmasked pin toggle");
    pin_in[0] = 1'b1;
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    clockEdge();
    checkOutput("pin0_edge1", 32'(mem_rdata[0]), 32'h0);
    clockEdge();
    checkOutput("pin0_edge2", 32'(mem_rdata[0]), 32'h1);
    repeat (2) clockEdge();
    applyStimulus(1'b0, BASE + 32'd12, 32'h0, 4'h0);
    #1 checkOutput("pcifr_unmasked", 32'(mem_rdata[7:0]), 32'h00);

    $display("[TB] reset during an access");
    applyStimulus(1'b1, BASE + 32'd4, 32'h0000_AA00, 4'b0010);
    rst_n = 1'b0;
    clockEdge();
    checkOutput("abort_ready", 32'(mem_ready), 32'h0);
    checkOutput("abort_ddr", 32'(pin_dir), 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    clockEdge();

    $display("[TB] randomized phase");
    for (int i = 0; i < 400; i++) begin
      ra = BASE - 32'd4 + 32'(4 * $urandom_range(0, NP + 2)) + 32'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 9) < 6, ra, $urandom,
                    ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0);
      if ($urandom_range(0, 3) == 0) pin_in = pin_in ^ W'($urandom & $urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      clockEdge();
    end
    rst_n = 1'b1;
    applyStimulus(1'b0, BASE, 32'h0, 4'h0);
    clockEdge();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_pcint.md
GPIO_PCINT -- requirements
Module: gpio_pcint

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of 8-bit ports (legal 1..8).
REQ-002 Parameter BASE_ADDR, default 32'h2000_0040, word-aligned base of the register block.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth (legal >=2).
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mem_valid  input  1  bus request.
REQ-007 mem_addr  input  32  byte address; bits [1:0] SHALL be ignored.
REQ-008 mem_wdata  input  32  write data.
REQ-009 mem_wstrb  input  4  byte write strobes; 0 means read.
REQ-010 mem_rdata  output  32  read data, combinational from the current address.
REQ-011 mem_ready  output  1  access-complete pulse.
REQ-012 pin_in  input  8*NUM_PORTS  asynchronous pad inputs; port p occupies bits [8p+7:8p].
REQ-013 pin_out  output  8*NUM_PORTS  PORT register values.
REQ-014 pin_dir  output  8*NUM_PORTS  DDR register values (1=output).
REQ-015 irq  output  1  level interrupt request.

Function
REQ-016 The word at BASE_ADDR+4p (p<NUM_PORTS) SHALL map: byte0 PIN, byte1 DDR, byte2 PORT, byte3 PCMSK.
REQ-017 The word at BASE_ADDR+4*NUM_PORTS SHALL map: byte0 PCIFR (bit p per port), byte1 PCICR (bit p per port); bytes 2-3 read 0, writes ignored; PCIFR/PCICR bits >=NUM_PORTS read 0.
REQ-018 Addresses outside these NUM_PORTS+1 words SHALL not be selected: mem_rdata=0, no mem_ready, no state change.
REQ-019 An access SHALL be accepted on a cycle with mem_valid=1, address selected and mem_ready=0; mem_ready SHALL be 1 exactly in the following cycle, then 0, even if mem_valid stays high.
REQ-020 Write effects SHALL occur only on the accepted cycle (one write per access).
REQ-021 PIN read SHALL return the synchroniser output (pin_in delayed by SYNC_STAGES edges).
REQ-022 Writing 1 to a PIN bit SHALL toggle the matching PORT bit, independent of DDR; writing 0 SHALL leave that bit unchanged.
REQ-023 If one access writes both the PIN and PORT bytes of a port, the PORT byte value SHALL win.
REQ-024 DDR, PORT, PCMSK and PCICR SHALL be read/write per strobed byte.
REQ-025 Pin-change event for port p: (sync_out XOR prev) AND PCMSK[p] nonzero, where prev is sync_out registered one edge later.
REQ-026 An event SHALL set PCIFR[p] on the next edge: pin edge to flag is SYNC_STAGES+1 clock edges.
REQ-027 Writing 1 to a PCIFR bit SHALL clear it; writing 0 SHALL leave it unchanged; an event in the same cycle as a clear SHALL win (flag stays 1).
REQ-028 irq SHALL be registered: irq = OR over p of (PCIFR[p] AND PCICR[p]), one edge after the flag/enable update.
REQ-029 Event detection SHALL be disabled by an arm counter until SYNC_STAGES+1 edges after reset release, so pins high at reset raise no flag.
REQ-030 PCICR gates irq only; flags SHALL set regardless of PCICR.

Reset
REQ-031 On rst_n=0: DDR, PORT, PCMSK, PCIFR, PCICR, synchroniser, prev, arm counter, mem_ready and irq SHALL be 0; pin_out=pin_dir=0.
REQ-032 Reset asserted mid-access SHALL abort the access with no mem_ready and no register change.

Verification
REQ-033 NUM_PORTS=3: write 32'h00_55_FF_00 strobe 4'b0110 to BASE+4 -> pin_dir[15:8]=FF, pin_out[15:8]=55; readback 0055FFxx (xx=PIN1).
REQ-034 PORT0=0x0F, write PIN0=0x3C with mem_valid held 3 cycles -> PORT0=0x33 (single toggle), one mem_ready pulse.
REQ-035 PCMSK2=0x01, PCICR=0x04, pin_in[16] 0->1 -> PCIFR=0x04 after 3 edges, irq=1 one edge later; write 0x04 to PCIFR -> irq=0.
REQ-036 Unmasked pin toggle (PCMSK=0) -> PCIFR unchanged; PIN read shows new value after 2 edges.
REQ-037 Event and PCIFR W1C on the same cycle -> flag remains 1.
REQ-038 pin_in all 1s through reset release -> PCIFR stays 0; access to BASE+16 -> no mem_ready, rdata 0.
